// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: bundles the sequencer's stream, neuron-array and status signals
//   enable/s_valid/s_data/s_ready          : input vector stream and start permission
//   nrn_rst/nrn_in_valid/nrn_in_data       : reset and input broadcast to the neuron array
//   nrn_out_valid/nrn_out_data             : per-neuron activation pulses and words
//   m_valid/m_data/m_last/m_ready          : output activation stream
//   busy/err                               : sequencer status
//   master = sequencer side, slave = surrounding adapters / neuron array
interface layer_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W = 16,
  parameter int NUM_NEURON = 30
);
  logic enable, s_valid, s_ready, nrn_rst, nrn_in_valid, m_valid, m_last, m_ready, busy, err;
  logic [DATA_W-1:0] s_data, nrn_in_data;
  logic [NUM_NEURON-1:0] nrn_out_valid;
  logic [NUM_NEURON*OUT_W-1:0] nrn_out_data;
  logic [OUT_W-1:0] m_data;
  modport master (
    input enable, s_valid, s_data, nrn_out_valid, nrn_out_data, m_ready,
    output s_ready, nrn_rst, nrn_in_valid, nrn_in_data, m_valid, m_data, m_last, busy, err
  );
  modport slave (
    output enable, s_valid, s_data, nrn_out_valid, nrn_out_data, m_ready,
    input s_ready, nrn_rst, nrn_in_valid, nrn_in_data, m_valid, m_data, m_last, busy, err
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: buffers an input vector, bursts it to a neuron array, collects and streams activations
//   clk : clock
//   rst : synchronous reset, active-low
//   bus : layer_sequencer_if.master
//         in  enable, s_valid, s_data, nrn_out_valid, nrn_out_data, m_ready
//         out s_ready, nrn_rst, nrn_in_valid, nrn_in_data, m_valid, m_data, m_last, busy, err
module layer_sequencer #(
  parameter int NUM_IN = 128,
  parameter int NUM_NEURON = 30,
  parameter int DATA_W = 16,
  parameter int OUT_W = 16,
  parameter int TIMEOUT = 512
) (
  input logic clk,
  input logic rst,
  layer_sequencer_if.master bus
);
  localparam int PW = $clog2(NUM_IN + 1);
  localparam int IW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  localparam int RW = $clog2(NUM_NEURON + 1);
  localparam int NW = NUM_NEURON > 1 ? $clog2(NUM_NEURON) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_DRAIN} state_t;
  state_t r_state;
  logic r_s_ready, r_nrn_rst, r_rst_hold, r_in_valid, r_m_valid, r_m_last, r_busy, r_err;
  logic [DATA_W-1:0] r_in_data;
  logic [OUT_W-1:0] r_m_data;
  logic [PW-1:0] r_wr_ptr, r_st_ptr;
  logic [RW-1:0] r_rd_ptr;
  logic [TW-1:0] r_timer;
  logic [NUM_NEURON-1:0] r_done;
  logic [DATA_W-1:0] r_in_buf [NUM_IN];
  logic [OUT_W-1:0] r_out_buf [NUM_NEURON];
  logic [NUM_NEURON-1:0] w_done;
  logic w_all, w_to, w_s_hs;
  logic [RW-1:0] w_rd_nx;
  logic [DATA_W-1:0] w_first;
  logic [OUT_W-1:0] w_buf_n [NUM_NEURON];
  // w_buf_n is the out_buf image after this WAIT cycle: fresh pulses captured,
  // and on timeout every still-missing neuron forced to zero
  always_comb begin
    w_done = r_done | bus.nrn_out_valid;
    w_all = &w_done;
    w_to = r_timer == TW'(TIMEOUT - 1);
    w_s_hs = bus.s_valid && r_s_ready;
    w_rd_nx = r_rd_ptr + RW'(1);
    // with a single-entry vector, word 0 is being written on the same edge STREAM starts
    w_first = r_wr_ptr == '0 ? bus.s_data : r_in_buf[0];
    for (int i = 0; i < NUM_NEURON; i++)
      w_buf_n[i] = bus.nrn_out_valid[i] && !r_done[i] ? bus.nrn_out_data[i*OUT_W +: OUT_W] :
                   w_to && !w_done[i] ? '0 : r_out_buf[i];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_s_ready <= 1'b0;
      r_in_valid <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last <= 1'b0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
      r_in_data <= '0;
      r_m_data <= '0;
      r_wr_ptr <= '0;
      r_st_ptr <= '0;
      r_rd_ptr <= '0;
      r_timer <= '0;
      r_done <= '0;
      r_nrn_rst <= 1'b1;
      r_rst_hold <= 1'b1;
    end else begin
      // r_rst_hold stretches the neuron reset one cycle past rst release
      r_rst_hold <= 1'b0;
      r_nrn_rst <= r_rst_hold;
      case (r_state)
        S_IDLE: if (bus.enable && !r_nrn_rst) begin
          r_state <= S_LOAD;
          r_s_ready <= 1'b1;
          r_busy <= 1'b1;
        end
        S_LOAD: if (w_s_hs) begin
          r_in_buf[r_wr_ptr[IW-1:0]] <= bus.s_data;
          r_wr_ptr <= r_wr_ptr + PW'(1);
          if (r_wr_ptr == PW'(NUM_IN - 1)) begin
            r_state <= S_STREAM;
            r_s_ready <= 1'b0;
            r_in_valid <= 1'b1;
            r_in_data <= w_first;
            r_st_ptr <= PW'(1);
          end
        end
        S_STREAM: if (r_st_ptr == PW'(NUM_IN)) begin
          r_state <= S_WAIT;
          r_in_valid <= 1'b0;
          r_timer <= '0;
        end else begin
          r_in_data <= r_in_buf[r_st_ptr[IW-1:0]];
          r_st_ptr <= r_st_ptr + PW'(1);
        end
        S_WAIT: begin
          r_out_buf <= w_buf_n;
          r_done <= w_done;
          r_timer <= r_timer + TW'(1);
          if (w_all || w_to) begin
            r_state <= S_DRAIN;
            r_m_valid <= 1'b1;
            r_m_data <= w_buf_n[0];
            r_m_last <= NUM_NEURON == 1;
            r_rd_ptr <= '0;
            if (!w_all) begin
              r_err <= 1'b1;
              r_nrn_rst <= 1'b1;
            end
          end
        end
        S_DRAIN: if (bus.m_ready) begin
          if (r_m_last) begin
            r_state <= bus.enable ? S_LOAD : S_IDLE;
            r_s_ready <= bus.enable;
            r_busy <= bus.enable;
            r_m_valid <= 1'b0;
            r_m_last <= 1'b0;
            r_done <= '0;
            r_wr_ptr <= '0;
            r_st_ptr <= '0;
            r_rd_ptr <= '0;
            r_timer <= '0;
          end else begin
            r_rd_ptr <= w_rd_nx;
            r_m_data <= r_out_buf[w_rd_nx[NW-1:0]];
            r_m_last <= w_rd_nx == RW'(NUM_NEURON - 1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.s_ready = r_s_ready;
  assign bus.nrn_rst = r_nrn_rst;
  assign bus.nrn_in_valid = r_in_valid;
  assign bus.nrn_in_data = r_in_data;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data = r_m_data;
  assign bus.m_last = r_m_last;
  assign bus.busy = r_busy;
  assign bus.err = r_err;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed vector table plus hand-written reset/recovery sequence for layer_sequencer
module tb_layer_sequencer;
  logic clk, rst;
  int checks, errors;
  layer_sequencer_if #(.DATA_W(16), .OUT_W(16), .NUM_NEURON(3)) bus ();
  layer_sequencer #(.NUM_IN(4), .NUM_NEURON(3), .DATA_W(16), .OUT_W(16), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic en, sv;
    logic [15:0] sd;
    logic [2:0] nov;
    logic [47:0] nod;
    logic mr, sr, nr, iv;
    logic [15:0] id;
    logic mv;
    logic [15:0] md;
    logic ml, bs, er;
  } vec_t;
  vec_t tbl[$];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic en, sv, input logic [15:0] sd, input logic [2:0] nov,
                     input logic [47:0] nod, input logic mr, sr, nr, iv, input logic [15:0] id,
                     input logic mv, input logic [15:0] md, input logic ml, bs, er);
    vec_t v;
    v = '{en, sv, sd, nov, nod, mr, sr, nr, iv, id, mv, md, ml, bs, er};
    tbl.push_back(v);
  endtask
  // start from IDLE: enable row (stray s_valid must not be taken), 4 loads,
  // 4-cycle burst with a stray neuron pulse that must be ignored, then WAIT entry
  task automatic vec_rows(input logic [15:0] b);
    add(1'b1, 1'b1, 16'hDEAD, 3'b0, 48'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, b + 16'(i), 3'b0, 48'h0, 1'b0, i < 3, 1'b0, i == 3, b, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++)
      add(1'b0, 1'b0, 16'h0, 3'b001, 48'hAA, 1'b0, 1'b0, 1'b0, 1'b1, b + 16'(i), 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask
  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.nrn_out_valid = '0;
    bus.nrn_out_data = '0;
    bus.m_ready = 1'b0;
    // separate pulses 2,0,1 with a repeat on 2, then 5 stalled drain cycles
    vec_rows(16'h1);
    add(1'b0, 1'b0, 16'h0, 3'b100, 48'h0030_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b100, 48'h00EE_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b001, 48'h0000_0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b010, 48'h0000_0020_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 16'h0, 3'b001, 48'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h10, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h20, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h30, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    // all three at once, then a repeat on neuron 0 that must not overwrite
    vec_rows(16'h5);
    add(1'b0, 1'b0, 16'h0, 3'b111, 48'h0033_0022_0011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h11, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b001, 48'h0000_0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h11, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h22, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h33, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    // neuron 1 never fires: timeout on the 16th WAIT cycle
    vec_rows(16'h9);
    add(1'b0, 1'b0, 16'h0, 3'b001, 48'h0000_0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b100, 48'h0030_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++)
      add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h10, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h00, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h30, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 16'h0, 3'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("reset s_ready", bus.s_ready, 1'b0);
    chk("reset nrn_rst", bus.nrn_rst, 1'b1);
    chk("reset nrn_in_valid", bus.nrn_in_valid, 1'b0);
    chk("reset nrn_in_data", bus.nrn_in_data, 16'h0);
    chk("reset m_valid", bus.m_valid, 1'b0);
    chk("reset m_data", bus.m_data, 16'h0);
    chk("reset m_last", bus.m_last, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset err", bus.err, 1'b0);
    rst = 1'b1;
    tick();
    chk("release nrn_rst hold", bus.nrn_rst, 1'b1);
    tick();
    chk("release nrn_rst drop", bus.nrn_rst, 1'b0);
    foreach (tbl[k]) begin
      bus.enable = tbl[k].en;
      bus.s_valid = tbl[k].sv;
      bus.s_data = tbl[k].sd;
      bus.nrn_out_valid = tbl[k].nov;
      bus.nrn_out_data = tbl[k].nod;
      bus.m_ready = tbl[k].mr;
      tick();
      chk($sformatf("row%0d s_ready", k), bus.s_ready, tbl[k].sr);
      chk($sformatf("row%0d nrn_rst", k), bus.nrn_rst, tbl[k].nr);
      chk($sformatf("row%0d nrn_in_valid", k), bus.nrn_in_valid, tbl[k].iv);
      if (tbl[k].iv) chk($sformatf("row%0d nrn_in_data", k), bus.nrn_in_data, tbl[k].id);
      chk($sformatf("row%0d m_valid", k), bus.m_valid, tbl[k].mv);
      if (tbl[k].mv) chk($sformatf("row%0d m_data", k), bus.m_data, tbl[k].md);
      chk($sformatf("row%0d m_last", k), bus.m_last, tbl[k].ml);
      chk($sformatf("row%0d busy", k), bus.busy, tbl[k].bs);
      chk($sformatf("row%0d err", k), bus.err, tbl[k].er);
    end
    bus.enable = 1'b0;
    bus.m_ready = 1'b0;
    bus.nrn_out_valid = '0;
    // reset pulse in the middle of a burst
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.s_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.s_data = 16'h41 + 16'(j);
      tick();
    end
    bus.s_valid = 1'b0;
    tick();
    chk("midrst streaming", bus.nrn_in_valid, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst nrn_in_valid", bus.nrn_in_valid, 1'b0);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst err cleared", bus.err, 1'b0);
    chk("midrst nrn_rst c1", bus.nrn_rst, 1'b1);
    tick();
    chk("midrst nrn_rst c2", bus.nrn_rst, 1'b1);
    tick();
    chk("midrst nrn_rst c3", bus.nrn_rst, 1'b0);
    // a fresh vector after the abort
    bus.enable = 1'b1;
    tick();
    chk("fresh s_ready", bus.s_ready, 1'b1);
    bus.enable = 1'b0;
    bus.s_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.s_data = 16'h51 + 16'(j);
      tick();
    end
    bus.s_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("fresh stream%0d valid", j), bus.nrn_in_valid, 1'b1);
      chk($sformatf("fresh stream%0d data", j), bus.nrn_in_data, 16'h51 + 16'(j));
      tick();
    end
    chk("fresh stream end", bus.nrn_in_valid, 1'b0);
    bus.nrn_out_valid = 3'b101;
    bus.nrn_out_data = 48'h000C_0000_000A;
    tick();
    bus.nrn_out_valid = 3'b010;
    bus.nrn_out_data = 48'h0000_000B_0000;
    tick();
    bus.nrn_out_valid = '0;
    n = 0;
    while (!bus.m_valid && n < 10) begin
      tick();
      n++;
    end
    chk("fresh m_valid arrives", bus.m_valid, 1'b1);
    bus.m_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("fresh out%0d valid", j), bus.m_valid, 1'b1);
      chk($sformatf("fresh out%0d data", j), bus.m_data, 16'h0A + 16'(j));
      chk($sformatf("fresh out%0d last", j), bus.m_last, j == 2);
      tick();
    end
    bus.m_ready = 1'b0;
    chk("fresh idle", bus.busy, 1'b0);
    chk("fresh m_valid low", bus.m_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
